// File: rtl/serial_frame_if.sv
// Handshake and serial-line bundle between a frame requester/consumer and serial_frame_ctrl.
interface serial_frame_if #(
  parameter int WIDTH = 4
) ();
  localparam int CW = $clog2(WIDTH + 1);

  logic             start;
  logic             serial_in;
  logic             out_ready;
  logic             shift;
  logic             busy;
  logic             out_valid;
  logic [WIDTH-1:0] data_out;
  logic [CW-1:0]    bit_cnt;
  logic             overrun;

  modport master (
    output start, serial_in, out_ready,
    input  shift, busy, out_valid, data_out, bit_cnt, overrun
  );

  modport slave (
    input  start, serial_in, out_ready,
    output shift, busy, out_valid, data_out, bit_cnt, overrun
  );
endinterface

// File: rtl/serial_frame_ctrl.sv
// Serial frame capture: runs WIDTH bit periods on start, then offers the assembled word
// on a valid/ready port until the consumer takes it.
module serial_frame_ctrl #(
  parameter int WIDTH        = 4,
  parameter int CLKS_PER_BIT = 1,
  parameter bit MSB_FIRST    = 1'b1
) (
  input  logic         clk,
  input  logic         rst,
  serial_frame_if.slave bus
);
  localparam int CW = $clog2(WIDTH + 1);
  localparam int DW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;

  typedef enum logic [1:0] {IDLE, SAMPLE, VALID} state_t;

  state_t           state_q, state_d;
  logic [DW-1:0]    div_cnt_q, div_cnt_d;
  logic [CW-1:0]    bit_cnt_q, bit_cnt_d;
  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic             valid_q, valid_d;
  logic             overrun_q, overrun_d;
  logic             shift_w, busy_w, last_bit_w;
  logic [WIDTH-1:0] shreg_nx;

  assign shreg_nx   = MSB_FIRST ? {shreg_q[WIDTH-2:0], bus.serial_in}
                                : {bus.serial_in, shreg_q[WIDTH-1:1]};
  assign last_bit_w = (bit_cnt_q == CW'(WIDTH - 1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= IDLE;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (bus.start) state_d = SAMPLE;
      SAMPLE:  if (shift_w && last_bit_w) state_d = VALID;
      VALID:   if (bus.out_ready) state_d = bus.start ? SAMPLE : IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    shift_w = (state_q == SAMPLE) && (div_cnt_q == DW'(CLKS_PER_BIT - 1));
    busy_w  = (state_q != IDLE);
  end

  // Datapath next-state; a start is rejected while a frame is being sampled or held.
  always_comb begin
    div_cnt_d = div_cnt_q;
    bit_cnt_d = bit_cnt_q;
    shreg_d   = shreg_q;
    data_d    = data_q;
    valid_d   = valid_q;
    overrun_d = bus.start && ((state_q == SAMPLE) || ((state_q == VALID) && !bus.out_ready));
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          div_cnt_d = '0;
          bit_cnt_d = '0;
        end
      end
      SAMPLE: begin
        if (shift_w) begin
          div_cnt_d = '0;
          shreg_d   = shreg_nx;
          bit_cnt_d = bit_cnt_q + CW'(1);
          if (last_bit_w) begin
            data_d  = shreg_nx;
            valid_d = 1'b1;
          end
        end else begin
          div_cnt_d = div_cnt_q + DW'(1);
        end
      end
      VALID: begin
        if (bus.out_ready) begin
          valid_d   = 1'b0;
          bit_cnt_d = '0;
          div_cnt_d = '0;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      div_cnt_q <= '0;
      bit_cnt_q <= '0;
      shreg_q   <= '0;
      data_q    <= '0;
      valid_q   <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      div_cnt_q <= div_cnt_d;
      bit_cnt_q <= bit_cnt_d;
      shreg_q   <= shreg_d;
      data_q    <= data_d;
      valid_q   <= valid_d;
      overrun_q <= overrun_d;
    end
  end

  assign bus.shift     = shift_w;
  assign bus.busy      = busy_w;
  assign bus.out_valid = valid_q;
  assign bus.data_out  = data_q;
  assign bus.bit_cnt   = bit_cnt_q;
  assign bus.overrun   = overrun_q;
endmodule

// File: tb/tb_serial_frame_ctrl.sv
// Directed bench: one MSB-first single-clock-per-bit instance and one LSB-first 3-clock instance.
module tb_serial_frame_ctrl;
  logic clk;
  logic rst;
  int   total;
  int   bad;
  int   shifts;

  serial_frame_if #(.WIDTH(4)) ia ();
  serial_frame_if #(.WIDTH(4)) ib ();

  serial_frame_ctrl #(.WIDTH(4), .CLKS_PER_BIT(1), .MSB_FIRST(1'b1)) dut_a (
    .clk (clk),
    .rst (rst),
    .bus (ia)
  );

  serial_frame_ctrl #(.WIDTH(4), .CLKS_PER_BIT(3), .MSB_FIRST(1'b0)) dut_b (
    .clk (clk),
    .rst (rst),
    .bus (ib)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Feeds four bits to dut_a, already in SAMPLE; bits[3] goes first.
  task automatic frame_a(input logic [3:0] bits, input string tag);
    shifts = 0;
    for (int i = 0; i < 4; i++) begin
      ia.serial_in = bits[3-i];
      if (ia.shift === 1'b1) shifts++;
      chk({tag, "_valid_lo"}, {31'd0, ia.out_valid}, 32'd0);
      tick();
    end
    ia.serial_in = 1'b0;
    chk({tag, "_shifts"}, shifts, 32'd4);
    chk({tag, "_valid"}, {31'd0, ia.out_valid}, 32'd1);
    chk({tag, "_shift_off"}, {31'd0, ia.shift}, 32'd0);
  endtask

  initial begin
    total = 0;
    bad   = 0;
    rst   = 1'b0;
    ia.start = 1'b0; ia.serial_in = 1'b0; ia.out_ready = 1'b0;
    ib.start = 1'b0; ib.serial_in = 1'b0; ib.out_ready = 1'b0;
    #12;
    chk("rst_busy",  {31'd0, ia.busy}, 32'd0);
    chk("rst_valid", {31'd0, ia.out_valid}, 32'd0);
    chk("rst_data",  {28'd0, ia.data_out}, 32'd0);
    chk("rst_cnt",   {29'd0, ia.bit_cnt}, 32'd0);
    rst = 1'b1;
    tick();
    tick();
    chk("idle_busy",  {31'd0, ia.busy}, 32'd0);
    chk("idle_shift", {31'd0, ia.shift}, 32'd0);

    // Reset mid-SAMPLE, between edges
    ia.start = 1'b1;
    tick();
    ia.start = 1'b0;
    ia.serial_in = 1'b1;
    tick();
    chk("mid_busy", {31'd0, ia.busy}, 32'd1);
    chk("mid_cnt",  {29'd0, ia.bit_cnt}, 32'd1);
    #2 rst = 1'b0;
    #1;
    chk("arst_busy",  {31'd0, ia.busy}, 32'd0);
    chk("arst_shift", {31'd0, ia.shift}, 32'd0);
    chk("arst_cnt",   {29'd0, ia.bit_cnt}, 32'd0);
    chk("arst_valid", {31'd0, ia.out_valid}, 32'd0);
    #1 rst = 1'b1;
    ia.serial_in = 1'b0;
    tick(); tick(); tick();
    chk("post_busy", {31'd0, ia.busy}, 32'd0);
    chk("post_cnt",  {29'd0, ia.bit_cnt}, 32'd0);

    // Basic frame 1,0,1,1
    ia.start = 1'b1;
    tick();
    ia.start = 1'b0;
    frame_a(4'b1011, "f1");
    chk("f1_data", {28'd0, ia.data_out}, 32'hB);
    chk("f1_cnt",  {29'd0, ia.bit_cnt}, 32'd4);

    // Backpressure, with serial_in toggling to show it is ignored
    for (int i = 0; i < 5; i++) begin
      ia.serial_in = i[0];
      tick();
      chk("bp_valid", {31'd0, ia.out_valid}, 32'd1);
      chk("bp_data",  {28'd0, ia.data_out}, 32'hB);
    end
    ia.out_ready = 1'b1;
    tick();
    ia.out_ready = 1'b0;
    chk("acc_valid", {31'd0, ia.out_valid}, 32'd0);
    chk("acc_busy",  {31'd0, ia.busy}, 32'd0);
    chk("acc_cnt",   {29'd0, ia.bit_cnt}, 32'd0);
    chk("acc_data",  {28'd0, ia.data_out}, 32'hB);

    // Back-to-back: 1,1,0,0 then 0,1,1,0 with no idle gap
    ia.start = 1'b1;
    tick();
    ia.start = 1'b0;
    frame_a(4'b1100, "f2");
    chk("f2_data", {28'd0, ia.data_out}, 32'hC);
    ia.start = 1'b1;
    ia.out_ready = 1'b1;
    tick();
    ia.start = 1'b0;
    ia.out_ready = 1'b0;
    chk("b2b_busy",  {31'd0, ia.busy}, 32'd1);
    chk("b2b_valid", {31'd0, ia.out_valid}, 32'd0);
    chk("b2b_ovr",   {31'd0, ia.overrun}, 32'd0);
    chk("b2b_shift", {31'd0, ia.shift}, 32'd1);
    frame_a(4'b0110, "f3");
    chk("f3_data", {28'd0, ia.data_out}, 32'h6);
    ia.out_ready = 1'b1;
    tick();
    ia.out_ready = 1'b0;

    // Overrun during SAMPLE: frame 1,0,0,1 with start on second bit
    ia.start = 1'b1;
    tick();
    ia.start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      ia.serial_in = (i == 0 || i == 3) ? 1'b1 : 1'b0;
      ia.start = (i == 1);
      tick();
      ia.start = 1'b0;
      chk("ovr_pulse", {31'd0, ia.overrun}, (i == 1) ? 32'd1 : 32'd0);
    end
    chk("ovr_data",  {28'd0, ia.data_out}, 32'h9);
    chk("ovr_valid", {31'd0, ia.out_valid}, 32'd1);

    // Overrun while VALID is held
    ia.start = 1'b1;
    tick();
    ia.start = 1'b0;
    chk("vovr_pulse", {31'd0, ia.overrun}, 32'd1);
    chk("vovr_valid", {31'd0, ia.out_valid}, 32'd1);
    tick();
    chk("vovr_clear", {31'd0, ia.overrun}, 32'd0);
    chk("vovr_data",  {28'd0, ia.data_out}, 32'h9);
    ia.out_ready = 1'b1;
    tick();
    ia.out_ready = 1'b0;
    chk("vovr_idle", {31'd0, ia.busy}, 32'd0);

    // LSB-first, 3 clocks per bit: 1,0,1,1 -> 1101; decoy value on non-sampling cycles
    ib.start = 1'b1;
    tick();
    ib.start = 1'b0;
    for (int n = 0; n < 4; n++) begin
      for (int c = 0; c < 3; c++) begin
        logic [3:0] bv;
        bv = 4'b1011;
        ib.serial_in = (c == 2) ? bv[3-n] : ~bv[3-n];
        chk("b_shift", {31'd0, ib.shift}, (c == 2) ? 32'd1 : 32'd0);
        chk("b_valid_lo", {31'd0, ib.out_valid}, 32'd0);
        tick();
      end
    end
    chk("b_valid", {31'd0, ib.out_valid}, 32'd1);
    chk("b_data",  {28'd0, ib.data_out}, 32'hD);
    chk("b_cnt",   {29'd0, ib.bit_cnt}, 32'd4);
    ib.out_ready = 1'b1;
    tick();
    ib.out_ready = 1'b0;
    chk("b_idle", {31'd0, ib.busy}, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
